uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames: 8 data bits, no parity, 1 stop bit, LSB first, line idle high. It is the receive-side counterpart of the top-level transmit path and accepts the same runtime 32-bit baud_rate and clock_frequency parameter. It uses 16x oversampling from a division-free fractional tick generator, with majority-vote bit sampling. It delivers each byte as a one-cycle data_valid strobe and flags bad stop bits.

---
 rtl/uart_receiver_if.sv | 31 +++
 rtl/uart_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_receiver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side line and byte-delivery signals of the 8N1 UART receiver.
// Latency: none; wires only.
// Backpressure: none; data_valid and framing_error are unconditional one-cycle strobes.
interface uart_receiver_if;
    logic [31:0] baud_rate;
    logic        rx;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        framing_error;
    logic        busy;

    // Line/config side drives baud_rate and rx and observes the byte outputs.
    modport master (
        output baud_rate,
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  baud_rate,
        input  rx,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x fractional oversampling and 3-sample majority vote per bit.
// Latency: data_valid about 9.625 bit times after the start edge, plus 2-3 clk for synchroniser and edge detect.
// Backpressure: none; each byte is offered once as a one-cycle strobe and is not held for a consumer.
module uart_receiver #(
    parameter int unsigned clock_frequency = 100000000
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [36:0] CLK_FREQ = 37'(clock_frequency);

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic [36:0] acc;
    logic [36:0] acc_sum;
    logic [36:0] acc_nxt;
    logic        tick;
    logic [3:0]  ti;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        samp7;
    logic        samp8;
    logic        maj;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        busy_q;

    assign bus.data_out      = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = busy_q;

    // Fractional tick: add 16*baud each cycle, wrap at clock_frequency; at most one tick per clk.
    always_comb begin
        acc_sum = acc + {1'b0, bus.baud_rate, 4'b0000};
        tick    = (acc_sum >= CLK_FREQ);
        acc_nxt = tick ? (acc_sum - CLK_FREQ) : acc_sum;
    end

    // Majority of the two stored window samples and the live third sample at ti=9.
    always_comb begin
        maj = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    end

    // Synchroniser, tick accumulator and frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            acc     <= '0;
            ti      <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            samp7   <= 1'b0;
            samp8   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            acc     <= acc_nxt;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (rx_prev && !rx_s) begin
                        // Restart the tick phase so ticks line up with this frame.
                        state  <= START;
                        acc    <= '0;
                        ti     <= '0;
                        busy_q <= 1'b1;
                    end
                end

                START, DATA, STOP: begin
                    if (tick) begin
                        ti <= ti + 4'd1;
                        if (ti == 4'd7) samp7 <= rx_s;
                        if (ti == 4'd8) samp8 <= rx_s;
                        if (ti == 4'd9) begin
                            case (state)
                                START: begin
                                    if (maj) begin
                                        // Start bit did not hold low: treat as noise.
                                        state  <= IDLE;
                                        busy_q <= 1'b0;
                                    end
                                end
                                DATA: begin
                                    shreg <= {maj, shreg[7:1]};
                                end
                                default: begin
                                    if (maj) begin
                                        // Leave at mid-stop so a back-to-back start edge is caught.
                                        data_q  <= shreg;
                                        valid_q <= 1'b1;
                                        state   <= IDLE;
                                        busy_q  <= 1'b0;
                                    end else begin
                                        ferr_q <= 1'b1;
                                        state  <= WAIT_IDLE;
                                    end
                                end
                            endcase
                        end
                        if (ti == 4'd15) begin
                            if (state == START) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else if (state == DATA) begin
                                if (bit_cnt == 3'd7) begin
                                    state <= STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                    end
                end

                WAIT_IDLE: begin
                    // Line held low (break or bad stop): wait for idle level before rearming.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized frames against a byte scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic reset;

    uart_receiver_if bus ();

    uart_receiver #(.clock_frequency(100000000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fe;
        logic [7:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got_e;
    logic [7:0]  last_good;
    int unsigned cyc      = 0;
    int unsigned edge_cyc = 0;
    bit          lat_chk  = 0;
    int          n_sent   = 0;
    int          n_seen   = 0;
    int          checks   = 0;
    int          fails    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every strobe must match the next expected frame outcome.
    always @(negedge clk) begin
        if (bus.data_valid || bus.framing_error) begin
            n_seen++;
            check("exclusive_strobes", {31'b0, bus.data_valid & bus.framing_error}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                got_e = exp_q.pop_front();
                check("event_kind", {31'b0, bus.framing_error}, {31'b0, got_e.fe});
                if (!got_e.fe) begin
                    check("data_out", {24'b0, bus.data_out}, {24'b0, got_e.dat});
                    last_good = got_e.dat;
                    if (lat_chk) begin
                        check("latency_window",
                              {31'b0, ((cyc - edge_cyc) >= 8335) && ((cyc - edge_cyc) <= 8375)}, 1);
                        lat_chk = 0;
                    end
                end else begin
                    check("data_hold_on_ferr", {24'b0, bus.data_out}, {24'b0, last_good});
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; optional inverted glitch centred in data bit gbit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk,
                              input int gbit, input int glen);
        exp_t e;
        int   half;
        e.fe  = ~stop;
        e.dat = b;
        exp_q.push_back(e);
        n_sent++;
        edge_cyc = cyc;
        hold(1'b0, bclk);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                half = (bclk - glen) / 2;
                hold(b[i], half);
                hold(~b[i], glen);
                hold(b[i], bclk - half - glen);
            end else begin
                hold(b[i], bclk);
            end
        end
        hold(stop, bclk);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (bus.busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.busy}, 0);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int bsel[3];
        int bclk;
        int gap;
        int n;
        logic [7:0] rb;
        logic bad;
        bsel[0] = 200;
        bsel[1] = 100;
        bsel[2] = 50;

        last_good     = 8'h00;
        reset         = 1'b0;
        bus.rx        = 1'b1;
        bus.baud_rate = 32'd115200;
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'b0, bus.data_out}, 0);
        check("rst_data_valid", {31'b0, bus.data_valid}, 0);
        check("rst_framing_error", {31'b0, bus.framing_error}, 0);
        check("rst_busy", {31'b0, bus.busy}, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame at 115200 with latency check.
        lat_chk = 1;
        send_frame(8'h25, 1'b1, 868, -1, 0);
        wait_idle("t1_idle", 2000);
        check("t1_events", n_seen, 1);

        // Short glitch in data bit 2 is voted out.
        send_frame(8'hC3, 1'b1, 868, 2, 100);
        wait_idle("t5_idle", 2000);
        check("t5_events", n_seen, 2);

        // Faster line for the remaining tests.
        bus.baud_rate = 32'd1000000;
        repeat (5) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 100, -1, 0);
        send_frame(8'hFF, 1'b1, 100, -1, 0);
        send_frame(8'hA5, 1'b1, 100, -1, 0);
        wait_idle("t2_idle", 500);
        check("t2_events", n_seen, 5);

        // Short low pulse: false start, no outputs.
        hold(1'b0, 10);
        check("t3_busy_during_pulse", {31'b0, bus.busy}, 1);
        hold(1'b0, 13);
        hold(1'b1, 1);
        wait_idle("t3_idle", 200);
        check("t3_events", n_seen, 5);

        // Bad stop bit with line held low, then recovery.
        send_frame(8'h5A, 1'b0, 100, -1, 0);
        check("t4_busy_after_ferr", {31'b0, bus.busy}, 1);
        hold(1'b0, 200);
        check("t4_busy_line_low", {31'b0, bus.busy}, 1);
        check("t4_events", n_seen, 6);
        hold(1'b1, 6);
        check("t4_busy_released", {31'b0, bus.busy}, 0);
        send_frame(8'h3C, 1'b1, 100, -1, 0);
        wait_idle("t4_idle", 500);
        check("t4_events_after", n_seen, 7);

        // Reset pulse in data bit 4 of a 0xF0 frame.
        hold(1'b0, 100);
        for (int i = 0; i < 4; i++) hold(1'b0, 100);
        hold(1'b1, 30);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_good = 8'h00;
        check("t6_rst_data_out", {24'b0, bus.data_out}, 0);
        check("t6_rst_valid", {31'b0, bus.data_valid}, 0);
        check("t6_rst_ferr", {31'b0, bus.framing_error}, 0);
        check("t6_rst_busy", {31'b0, bus.busy}, 0);
        hold(1'b1, 69 + 300 + 100);
        check("t6_busy_after", {31'b0, bus.busy}, 0);
        check("t6_events", n_seen, 7);
        send_frame(8'h81, 1'b1, 100, -1, 0);
        wait_idle("t6_idle", 500);
        check("t6_events_after", n_seen, 8);

        // Randomized frames, line rate changed only while idle.
        for (int k = 0; k < 20; k++) begin
            bclk = bsel[$urandom_range(0, 2)];
            bus.baud_rate = 32'(100000000 / bclk);
            hold(1'b1, $urandom_range(5, 40));
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(rb, ~bad, bclk, -1, 0);
            if (bad) begin
                hold(1'b0, bclk);
                hold(1'b1, 1);
            end
            gap = $urandom_range(5, 40);
            hold(1'b1, gap);
            wait_idle("rand_idle", 4 * bclk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", exp_q.size(), 0);
        check("event_count", n_seen, n_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
